// File: rtl/tile_bank_cfg_writer.sv
// Bank config writer: streams one BL word per row onto bl, pulses wl one-hot per row.
// Row latency 3+PULSE_CYCLES cycles; optional parity abort under CFG_BANK_PARITY_EN.
// Backpressure: din_ready high only in LOAD; the writer waits there indefinitely.
module tile_bank_cfg_writer #(
  parameter int BL_WIDTH     = 40,
  parameter int WL_WIDTH     = 4,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                start,
  input  logic [BL_WIDTH-1:0] din,
  input  logic                din_parity,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [BL_WIDTH-1:0] bl,
  output logic [WL_WIDTH-1:0] wl,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int RW = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [RW-1:0] LAST_ROW   = RW'(WL_WIDTH - 1);
  localparam logic [PW-1:0] LAST_PULSE = PW'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, PULSE, HOLD, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row;
  logic [PW-1:0] pcnt;
  logic          par_bad;

`ifdef CFG_BANK_PARITY_EN
  assign par_bad = ^{din, din_parity};
`else
  logic unused_parity;
  assign unused_parity = din_parity;
  assign par_bad       = 1'b0;
`endif

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    wl        = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        din_ready = 1'b1;
        if (din_valid) state_nxt = par_bad ? DONE : SETUP;
      end
      SETUP: state_nxt = PULSE;
      PULSE: begin
        wl = WL_WIDTH'(1) << row;
        if (pcnt == LAST_PULSE) state_nxt = HOLD;
      end
      HOLD:  state_nxt = (row == LAST_ROW) ? DONE : LOAD;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bl is cleared on every path into DONE, including a parity abort
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      row  <= '0;
      pcnt <= '0;
      bl   <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row <= '0;
            err <= 1'b0;
          end
        end
        LOAD: begin
          if (din_valid) begin
            if (par_bad) begin
              err <= 1'b1;
              bl  <= '0;
            end else begin
              bl <= din;
            end
          end
        end
        PULSE: pcnt <= (pcnt == LAST_PULSE) ? '0 : pcnt + 1'b1;
        HOLD: begin
          if (row == LAST_ROW) bl  <= '0;
          else                 row <= row + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_bank_cfg_writer.sv
// Directed bench for tile_bank_cfg_writer: default instance plus a 1-row/1-pulse instance.
module tb_tile_bank_cfg_writer;

  logic        prog_clk = 1'b0;
  logic        prog_reset_n;
  logic        start, din_parity, din_valid;
  logic [39:0] din;
  logic        din_ready, busy, done, err;
  logic [39:0] bl;
  logic [3:0]  wl;

  logic        s_start, s_par, s_valid, s_rdy, s_busy, s_done, s_err;
  logic [39:0] s_din, s_bl;
  logic [0:0]  s_wl;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] words [4];

  always #5 prog_clk = ~prog_clk;

  tile_bank_cfg_writer dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
    .din(din), .din_parity(din_parity), .din_valid(din_valid),
    .din_ready(din_ready), .bl(bl), .wl(wl), .busy(busy), .done(done), .err(err)
  );

  tile_bank_cfg_writer #(.BL_WIDTH(40), .WL_WIDTH(1), .PULSE_CYCLES(1)) dut_s (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(s_start),
    .din(s_din), .din_parity(s_par), .din_valid(s_valid),
    .din_ready(s_rdy), .bl(s_bl), .wl(s_wl), .busy(s_busy), .done(s_done), .err(s_err)
  );

  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic test_reset;
    prog_reset_n = 1'b0;
    start = 0; din = '0; din_parity = 0; din_valid = 0;
    s_start = 0; s_din = '0; s_par = 0; s_valid = 0;
    tick(); tick();
    n_checks++;
    if ({din_ready, busy, done, err, wl, bl} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_main got rdy=%b busy=%b done=%b err=%b wl=%b bl=%h exp all 0",
               din_ready, busy, done, err, wl, bl);
    end
    n_checks++;
    if ({s_rdy, s_busy, s_done, s_err, s_wl, s_bl} !== 45'h0) begin
      n_fail++;
      $display("FAIL reset_small got rdy=%b busy=%b done=%b wl=%b bl=%h exp all 0",
               s_rdy, s_busy, s_done, s_wl, s_bl);
    end
    prog_reset_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start busy got=%b exp=0", busy);
    end
  endtask

  // stall: din_valid low for 7 cycles at the start of row 2 (cycles 11..17)
  task automatic run_frame(input bit stall, input int last_c, input string name);
    int r, ph, e;
    logic [39:0] e_bl;
    logic [6:0]  got, exp;
    start = 1; din_valid = 1; din = words[0]; din_parity = ^words[0];
    tick();
    start = 0;
    for (int c = 1; c <= last_c; c++) begin
      if (!stall)       e = c;
      else if (c < 11)  e = c;
      else if (c <= 18) e = 11;
      else              e = c - 7;
      din_valid = !(stall && c >= 11 && c <= 17);
      r  = (e - 1) / 5;
      ph = (e - 1) % 5;
      exp[6]   = (e <= 20) && (ph == 0);
      exp[5]   = (e <= 21);
      exp[4]   = (e == 21);
      exp[3:0] = (e <= 20 && (ph == 2 || ph == 3)) ? 4'(1 << r) : 4'b0;
      if (e > 20)       e_bl = '0;
      else if (ph == 0) e_bl = (r == 0) ? 40'h0 : words[r-1];
      else              e_bl = words[r];
      got = {din_ready, busy, done, wl};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s_ctl c=%0d got rdy,busy,done,wl=%b exp=%b", name, c, got, exp);
      end
      n_checks++;
      if (bl !== e_bl) begin
        n_fail++;
        $display("FAIL %s_bl c=%0d got=%h exp=%h", name, c, bl, e_bl);
      end
      if (e <= 20 && ph == 0) begin
        din = words[r]; din_parity = ^words[r];
      end
      tick();
    end
    din_valid = 0;
  endtask

  task automatic test_full_frame;
    run_frame(1'b0, 22, "frame");
  endtask

  task automatic test_backpressure;
    run_frame(1'b1, 29, "bp");
  endtask

  task automatic test_start_ignored;
    int pulse_cyc = 0, done_cnt = 0, done_cyc = 0;
    logic [3:0] mask = '0;
    start = 1; din_valid = 1; din = words[0]; din_parity = 0;
    tick();
    start = 0;
    for (int c = 1; c <= 26; c++) begin
      start = (c == 8);
      if (wl != 0) begin
        pulse_cyc++;
        mask |= wl;
      end
      n_checks++;
      if (!$onehot0(wl)) begin
        n_fail++;
        $display("FAIL start_ign_onehot c=%0d got wl=%b exp one-hot or zero", c, wl);
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      tick();
    end
    start = 0; din_valid = 0;
    n_checks++;
    if (pulse_cyc != 8 || mask !== 4'hF) begin
      n_fail++;
      $display("FAIL start_ign_rows got pulse_cycles=%0d mask=%b exp 8 1111", pulse_cyc, mask);
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != 21) begin
      n_fail++;
      $display("FAIL start_ign_done got count=%0d cycle=%0d exp 1 21", done_cnt, done_cyc);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ign_idle busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_mid_reset;
    start = 1; din_valid = 1; din = words[2]; din_parity = 0;
    tick();
    start = 0;
    for (int c = 1; c < 13; c++) tick();
    n_checks++;
    if (wl !== 4'b0100) begin
      n_fail++;
      $display("FAIL midrst_pre wl got=%b exp=0100", wl);
    end
    prog_reset_n = 0;
    tick();
    prog_reset_n = 1;
    n_checks++;
    if ({wl, bl, busy, din_ready, done} !== 47'h0) begin
      n_fail++;
      $display("FAIL midrst_post got wl=%b bl=%h busy=%b rdy=%b done=%b exp all 0",
               wl, bl, busy, din_ready, done);
    end
    din = words[1];
    start = 1;
    tick();
    start = 0;
    n_checks++;
    if (din_ready !== 1'b1 || bl !== 40'h0) begin
      n_fail++;
      $display("FAIL midrst_restart c=1 got rdy=%b bl=%h exp 1 0", din_ready, bl);
    end
    tick(); tick();
    n_checks++;
    if (wl !== 4'b0001 || bl !== words[1]) begin
      n_fail++;
      $display("FAIL midrst_row0 c=3 got wl=%b bl=%h exp 0001 %h", wl, bl, words[1]);
    end
    for (int i = 0; i < 20; i++) tick();
    din_valid = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_finish busy got=%b exp=0", busy);
    end
  endtask

  // row 1 carries din=0x01 with parity 0 (odd overall)
  task automatic test_parity;
    int r, ph;
    bit saw_wl1 = 0;
    start = 1; din_valid = 1; din = words[0]; din_parity = ^words[0];
    tick();
    start = 0;
    for (int c = 1; c <= 22; c++) begin
      r  = (c - 1) / 5;
      ph = (c - 1) % 5;
      if (wl[1]) saw_wl1 = 1;
`ifdef CFG_BANK_PARITY_EN
      if (c == 3) begin
        n_checks++;
        if (wl !== 4'b0001 || bl !== words[0]) begin
          n_fail++;
          $display("FAIL par_row0 got wl=%b bl=%h exp 0001 %h", wl, bl, words[0]);
        end
      end
      if (c == 7) begin
        n_checks++;
        if ({done, err, busy} !== 3'b111 || bl !== 40'h0) begin
          n_fail++;
          $display("FAIL par_abort got done,err,busy=%b bl=%h exp 111 0",
                   {done, err, busy}, bl);
        end
      end
      if (c == 12) begin
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL par_sticky got err=%b busy=%b exp 1 0", err, busy);
        end
      end
`else
      if (c == 8) begin
        n_checks++;
        if (wl !== 4'b0010 || bl !== 40'h1) begin
          n_fail++;
          $display("FAIL par_ignored got wl=%b bl=%h exp 0010 1", wl, bl);
        end
      end
      if (c == 21) begin
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
          n_fail++;
          $display("FAIL par_off_done got done=%b err=%b exp 1 0", done, err);
        end
      end
`endif
      if (c <= 20 && ph == 0) begin
        din        = (r == 1) ? 40'h1 : words[r];
        din_parity = (r == 1) ? 1'b0 : ^words[r];
      end
      tick();
    end
`ifdef CFG_BANK_PARITY_EN
    n_checks++;
    if (saw_wl1) begin
      n_fail++;
      $display("FAIL par_no_wl1 got wl[1] pulse=1 exp=0");
    end
    din = words[0]; din_parity = ^words[0];
    start = 1;
    tick();
    start = 0;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL par_clear got err=%b exp=0", err);
    end
    for (int i = 0; i < 22; i++) tick();
`else
    n_checks++;
    if (!saw_wl1) begin
      n_fail++;
      $display("FAIL par_off_wl1 got wl[1] pulse=0 exp=1");
    end
`endif
    din_valid = 0;
  endtask

  task automatic test_single_row;
    logic [3:0] got, exp;
    s_start = 1; s_valid = 1; s_din = 40'h3; s_par = 0;
    tick();
    s_start = 0;
    for (int c = 1; c <= 6; c++) begin
      exp = {(c == 1), (c <= 5), (c == 5), (c == 3)};
      got = {s_rdy, s_busy, s_done, s_wl[0]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single_ctl c=%0d got rdy,busy,done,wl=%b exp=%b", c, got, exp);
      end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (s_bl !== 40'h3) begin
          n_fail++;
          $display("FAIL single_bl c=%0d got=%h exp=3", c, s_bl);
        end
      end
      tick();
    end
    s_valid = 0;
  endtask

  initial begin
    words[0] = 40'h00000000A5;
    words[1] = 40'h5A00000000;
    words[2] = 40'hFFFFFFFFFF;
    words[3] = 40'h0000000001;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_start_ignored();
    test_mid_reset();
    test_parity();
    test_single_row();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
